mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter XLEN, 32, data/address width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 valid_in  in  1  EX/MEM slot holds a real instruction.
REQ-005 Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_RegWrite_in, Ctl_MemtoReg_in  in  1 each  EX/MEM control.
REQ-006 Funct3_in  in  3  access size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU.
REQ-007 Rd_in  in  5; ALUresult_in  in  32 (byte address or ALU result); WriteData_in  in  32 (store data, rs2).
REQ-008 stall_out  out  1  freezes IF/ID/EX; upstream holds all inputs stable while high.
REQ-009 dmem_req, dmem_we  out  1; dmem_addr  out  32; dmem_be  out  4; dmem_wdata  out  32.
REQ-010 dmem_gnt, dmem_rvalid  in  1; dmem_rdata  in  32.
REQ-011 err_out  out  1  one-cycle pulse on a misaligned access or illegal Funct3.
REQ-012 Ctl_RegWrite_out, Ctl_MemtoReg_out  out  1; Rd_out  out  5; ReadDatafromMem_out, ALUresult_out  out  32: registered MEM/WB outputs to the WB stage.

Function
REQ-013 FSM states: IDLE, REQ, WAIT.
REQ-014 Non-memory op (valid_in=1, MemRead=MemWrite=0): no bus activity, no stall; inputs appear on the MEM/WB outputs one edge later.
REQ-015 Memory op in IDLE: dmem_req=1 in the same cycle (combinational); if gnt=0, go to REQ and hold req/we/addr/be/wdata constant until gnt.
REQ-016 Store: completes in the cycle gnt=1, from IDLE or REQ, then returns to IDLE; a zero-wait store therefore causes no stall.
REQ-017 Load: on gnt go to WAIT; in WAIT, rvalid=1 completes and returns to IDLE; minimum latency 2 cycles.
REQ-018 stall_out = valid memory op AND NOT completing in this cycle.
REQ-019 On completion edge: capture MEM/WB outputs; while stalled, MEM/WB outputs carry a bubble (Ctl_RegWrite_out=0).
REQ-020 dmem_addr = {ALUresult_in[31:2],2'b00}; dmem_we=1 only for stores.
REQ-021 Store byte enables: SB 4'b0001<<addr[1:0]; SH 4'b0011<<addr[1:0]; SW 4'b1111.
REQ-022 Store data: SB replicates the byte 4x; SH replicates the half 2x; SW passes through.
REQ-023 Load: lane = addr[1:0]; B/BU select rdata[8*lane+:8], H/HU select rdata[16*addr[1]+:16]; sign-extend B/H, zero-extend BU/HU.
REQ-024 Misaligned (H with addr[0]=1, W with addr[1:0]!=0) or illegal Funct3 (load 3/6/7, store >=3): no dmem_req, no stall, err_out pulses on the next edge, Ctl_RegWrite_out=0.
REQ-025 MemRead and MemWrite both set: treated as a load; the store is suppressed.
REQ-026 Rd_in=0: Ctl_RegWrite_out forced 0.
REQ-027 valid_in=0: bubble into MEM/WB outputs, no bus activity.
REQ-028 dmem_rvalid outside WAIT and dmem_gnt outside IDLE/REQ are ignored.

Reset
REQ-029 rst_n low: FSM to IDLE immediately, every output 0 (including dmem_req and stall_out).
REQ-030 Reset during REQ/WAIT: the request is abandoned and a late rvalid after reset is ignored.

Structure
REQ-031 Shared package mem_pkg: Funct3 encodings, FSM state encoding, byte-enable constants.
REQ-032 One combinational sub-module load_align (rdata, addr[1:0], Funct3 -> extended 32-bit load data).

Verification
REQ-033 ADD with ALUresult=0x1234, Rd=5, RegWrite=1 -> next edge ALUresult_out=0x1234, Rd_out=5, stall_out never high.
REQ-034 SB addr=0x103, data=0xAB, gnt=1 immediately -> be=4'b1000, wdata=0xABABABAB, addr=0x100, no stall.
REQ-035 LB addr=0x102, gnt after 2 cycles, rvalid 1 cycle later, rdata=0x00800000 -> ReadDatafromMem_out=0xFFFFFF80; stall_out high for 3 cycles.
REQ-036 LW addr=0x206 -> no dmem_req, err_out one-cycle pulse, Ctl_RegWrite_out=0.
REQ-037 LHU addr=0x2, rdata=0xBEEF1234 -> ReadDatafromMem_out=0x0000BEEF.
REQ-038 rst_n low while in WAIT, then rvalid after release -> all outputs 0, FSM IDLE, response ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the MEM stage.
//   - Funct3 access size/sign codes
//   - MEM stage FSM state type
//   - base byte-enable patterns (shifted by the address lane)
//   - helpers that classify an access as illegal or misaligned
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } mem_state_t;

    // Stores only know B/H/W; loads also accept the unsigned variants.
    function automatic logic f3_legal(input logic [2:0] f3, input logic is_load);
        logic ok;
        case (f3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = is_load;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Size is carried in f3[1:0] for both signed and unsigned variants.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/response bus.
//   master (MEM stage): drives dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata;
//                       receives dmem_gnt, dmem_rvalid, dmem_rdata.
//   slave  (memory):    the mirror image.
interface mem_stage_if #(parameter int XLEN = 32);

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half out of a read word and extends it.
//   rdata   in  32  raw word from memory
//   addr_lo in  2   byte address bits [1:0]
//   funct3  in  3   access size/sign code
//   data    out 32  sign- or zero-extended load value (0 for unknown codes)
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        half_sel = 16'h0000;
        data     = 32'h0000_0000;

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_W:    data = rdata;
            F3_BU:   data = {24'h00_0000, byte_sel};
            F3_HU:   data = {16'h0000, half_sel};
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a req/gnt + rvalid data-memory bus.
//   clk, rst_n           clock, async active-low reset
//   valid_in, Ctl_*_in   EX/MEM slot and its control bits
//   Funct3_in, Rd_in     access size/sign, destination register
//   ALUresult_in         byte address (memory ops) or ALU result
//   WriteData_in         store data
//   stall_out            holds IF/ID/EX while a memory op is outstanding
//   err_out              one-cycle pulse for a misaligned/illegal access
//   Ctl_*_out, Rd_out, ReadDatafromMem_out, ALUresult_out   registered MEM/WB
//   dmem                 data-memory bus (master side)
//
// state | meaning
// IDLE  | no access outstanding; a new memory op requests combinationally
// REQ   | request presented, waiting for dmem_gnt; bus fields held
// WAIT  | load granted, waiting for dmem_rvalid
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            Ctl_MemRead_in,
    input  logic            Ctl_MemWrite_in,
    input  logic            Ctl_RegWrite_in,
    input  logic            Ctl_MemtoReg_in,
    input  logic [2:0]      Funct3_in,
    input  logic [4:0]      Rd_in,
    input  logic [XLEN-1:0] ALUresult_in,
    input  logic [XLEN-1:0] WriteData_in,
    output logic            stall_out,
    output logic            err_out,
    output logic            Ctl_RegWrite_out,
    output logic            Ctl_MemtoReg_out,
    output logic [4:0]      Rd_out,
    output logic [XLEN-1:0] ReadDatafromMem_out,
    output logic [XLEN-1:0] ALUresult_out,
    mem_stage_if.master     dmem
);

    mem_state_t state, state_nxt;

    logic            mem_op;
    logic            is_load;
    logic            is_store;
    logic            bad;
    logic            mem_ok;
    logic            issuing;
    logic            done;
    logic [3:0]      be_calc;
    logic [XLEN-1:0] wdata_calc;
    logic [XLEN-1:0] load_data;

    // Read+write together is treated as a load, so the store side is masked.
    assign mem_op   = valid_in & (Ctl_MemRead_in | Ctl_MemWrite_in);
    assign is_load  = Ctl_MemRead_in;
    assign is_store = Ctl_MemWrite_in & ~Ctl_MemRead_in;
    assign bad      = mem_op & (~f3_legal(Funct3_in, is_load) |
                                misaligned(Funct3_in, ALUresult_in[1:0]));
    assign mem_ok   = mem_op & ~bad;
    assign issuing  = mem_ok & (state != ST_WAIT);
    assign done     = (is_store & issuing & dmem.dmem_gnt) |
                      (is_load & mem_ok & (state == ST_WAIT) & dmem.dmem_rvalid);

    always_comb begin
        be_calc    = BE_WORD;
        wdata_calc = WriteData_in;
        case (Funct3_in[1:0])
            2'b00: begin
                be_calc    = 4'(BE_BYTE << ALUresult_in[1:0]);
                wdata_calc = {4{WriteData_in[7:0]}};
            end
            2'b01: begin
                be_calc    = 4'(BE_HALF << ALUresult_in[1:0]);
                wdata_calc = {2{WriteData_in[15:0]}};
            end
            default: begin
                be_calc    = BE_WORD;
                wdata_calc = WriteData_in;
            end
        endcase
    end

    load_align u_load_align (
        .rdata   (dmem.dmem_rdata),
        .addr_lo (ALUresult_in[1:0]),
        .funct3  (Funct3_in),
        .data    (load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus outputs are gated by rst_n so they drop the moment reset asserts,
    // even though they are formed combinationally from held upstream inputs.
    always_comb begin
        state_nxt        = state;
        dmem.dmem_req    = 1'b0;
        dmem.dmem_we     = 1'b0;
        dmem.dmem_addr   = '0;
        dmem.dmem_be     = 4'b0000;
        dmem.dmem_wdata  = '0;
        stall_out        = rst_n & mem_ok & ~done;

        case (state)
            ST_IDLE, ST_REQ: begin
                if (mem_ok) begin
                    if (dmem.dmem_gnt) begin
                        state_nxt = is_load ? ST_WAIT : ST_IDLE;
                    end else begin
                        state_nxt = ST_REQ;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dmem.dmem_rvalid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (rst_n && issuing) begin
            dmem.dmem_req   = 1'b1;
            dmem.dmem_we    = is_store;
            dmem.dmem_addr  = {ALUresult_in[XLEN-1:2], 2'b00};
            dmem.dmem_be    = be_calc;
            dmem.dmem_wdata = is_store ? wdata_calc : '0;
        end
    end

    // MEM/WB register: captures on completion, otherwise carries a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_out             <= 1'b0;
            Ctl_RegWrite_out    <= 1'b0;
            Ctl_MemtoReg_out    <= 1'b0;
            Rd_out              <= 5'd0;
            ReadDatafromMem_out <= '0;
            ALUresult_out       <= '0;
        end else begin
            err_out <= bad;
            if (valid_in && !bad && (!mem_op || done)) begin
                Ctl_RegWrite_out    <= Ctl_RegWrite_in & (Rd_in != 5'd0);
                Ctl_MemtoReg_out    <= Ctl_MemtoReg_in;
                Rd_out              <= Rd_in;
                ALUresult_out       <= ALUresult_in;
                ReadDatafromMem_out <= (mem_op && is_load) ? load_data : '0;
            end else begin
                Ctl_RegWrite_out    <= 1'b0;
                Ctl_MemtoReg_out    <= 1'b0;
                Rd_out              <= 5'd0;
                ALUresult_out       <= '0;
                ReadDatafromMem_out <= '0;
            end
        end
    end

endmodule
